// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared store buffer constants, types and match classification
package store_buffer_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_HIT   = 2'd1,
    FWD_STALL = 2'd2
  } fwd_kind_e;

  // Only a full-word store at the exact byte offset can satisfy a load on its own.
  function automatic fwd_kind_e classify_match(
    input logic       hit,
    input logic [3:0] entry_be,
    input logic [1:0] entry_off,
    input logic [1:0] load_off
  );
    if (!hit)
      return FWD_NONE;
    else if (entry_be == BE_WORD && entry_off == load_off)
      return FWD_HIT;
    else
      return FWD_STALL;
  endfunction

endpackage

// File: rtl/store_buffer_fwd_match.sv
// rtl/store_buffer_fwd_match.sv - youngest-match search of buffered stores for a load
module store_buffer_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = PTR_W + 1
) (
  input  logic [ADDR_W-1:0]   entry_addr [DEPTH],
  input  logic [DATA_W-1:0]   entry_data [DEPTH],
  input  logic [DATA_W/8-1:0] entry_be   [DEPTH],
  input  logic [PTR_W-1:0]    head,
  input  logic [CNT_W-1:0]    count,
  input  logic                load_request,
  input  logic [ADDR_W-1:0]   load_addr,
  output logic                forward_valid,
  output logic [DATA_W-1:0]   forward_data,
  output logic                forward_stall
);

  logic             hit;
  logic [PTR_W-1:0] hit_idx;
  logic [PTR_W-1:0] idx;
  fwd_kind_e        kind;

  // Walk oldest to youngest so the last match seen is the one nearest the tail.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (CNT_W'(i) < count &&
          entry_addr[idx][ADDR_W-1:2] == load_addr[ADDR_W-1:2]) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  always_comb begin
    kind = classify_match(hit && load_request, entry_be[hit_idx],
                          entry_addr[hit_idx][1:0], load_addr[1:0]);
    forward_valid = (kind == FWD_HIT);
    forward_stall = (kind == FWD_STALL);
    forward_data  = (kind == FWD_NONE) ? '0 : entry_data[hit_idx];
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - committed-store FIFO draining to data memory with load forwarding
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                capture_store,
  input  logic [ADDR_W-1:0]   store_addr,
  input  logic [DATA_W-1:0]   store_data,
  input  logic [DATA_W/8-1:0] store_byte_en,
  input  logic                load_request,
  input  logic [ADDR_W-1:0]   load_addr,
  output logic                forward_valid,
  output logic [DATA_W-1:0]   forward_data,
  output logic                forward_stall,
  output logic                buffer_full,
  output logic                buffer_empty,
  output logic                misaligned_drop,
  output logic                mem_wr_en,
  output logic [ADDR_W-1:0]   mem_wr_addr,
  output logic [DATA_W-1:0]   mem_wr_data,
  output logic [DATA_W/8-1:0] mem_wr_byte_en,
  input  logic                mem_wr_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]   entry_addr [DEPTH];
  logic [DATA_W-1:0]   entry_data [DEPTH];
  logic [DATA_W/8-1:0] entry_be   [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  assign buffer_full  = (count == CNT_W'(DEPTH));
  assign buffer_empty = (count == '0);

  // Full blocks the push even when the head pops in the same cycle.
  assign push = capture_store && !buffer_full && (store_byte_en != BE_NONE);

  // Loads own the memory port, so draining yields whenever one is issued.
  assign mem_wr_en      = !buffer_empty && !load_request;
  assign mem_wr_addr    = entry_addr[head];
  assign mem_wr_data    = entry_data[head];
  assign mem_wr_byte_en = entry_be[head];
  assign pop            = mem_wr_en && mem_wr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      misaligned_drop <= 1'b0;
    end else begin
      if (push)
        tail <= tail + 1'b1;
      if (pop)
        head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      misaligned_drop <= capture_store && (store_byte_en == BE_NONE);
    end
  end

  // Entry payloads carry no reset; count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_addr[tail] <= store_addr;
      entry_data[tail] <= store_data;
      entry_be[tail]   <= store_byte_en;
    end
  end

  store_buffer_fwd_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W),
    .CNT_W  (CNT_W)
  ) u_fwd_match (
    .entry_addr    (entry_addr),
    .entry_data    (entry_data),
    .entry_be      (entry_be),
    .head          (head),
    .count         (count),
    .load_request  (load_request),
    .load_addr     (load_addr),
    .forward_valid (forward_valid),
    .forward_data  (forward_data),
    .forward_stall (forward_stall)
  );

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        capture_store = 1'b0;
  logic [31:0] store_addr = '0;
  logic [31:0] store_data = '0;
  logic [3:0]  store_byte_en = '0;
  logic        load_request = 1'b0;
  logic [31:0] load_addr = '0;
  logic        forward_valid;
  logic [31:0] forward_data;
  logic        forward_stall;
  logic        buffer_full;
  logic        buffer_empty;
  logic        misaligned_drop;
  logic        mem_wr_en;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_byte_en;
  logic        mem_wr_ready = 1'b0;

  int  n_checks = 0;
  int  n_fail   = 0;
  wr_t sb[$];

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .capture_store   (capture_store),
    .store_addr      (store_addr),
    .store_data      (store_data),
    .store_byte_en   (store_byte_en),
    .load_request    (load_request),
    .load_addr       (load_addr),
    .forward_valid   (forward_valid),
    .forward_data    (forward_data),
    .forward_stall   (forward_stall),
    .buffer_full     (buffer_full),
    .buffer_empty    (buffer_empty),
    .misaligned_drop (misaligned_drop),
    .mem_wr_en       (mem_wr_en),
    .mem_wr_addr     (mem_wr_addr),
    .mem_wr_data     (mem_wr_data),
    .mem_wr_byte_en  (mem_wr_byte_en),
    .mem_wr_ready    (mem_wr_ready)
  );

  always #5 clk = ~clk;

  // Every accepted memory write must match the oldest expected store.
  always @(negedge clk) begin
    if (!rst && mem_wr_en && mem_wr_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL mem_write_unexpected: got addr=%h data=%h be=%b, required no write",
                 mem_wr_addr, mem_wr_data, mem_wr_byte_en);
      end else begin
        wr_t exp;
        exp = sb.pop_front();
        if ({mem_wr_addr, mem_wr_data, mem_wr_byte_en} !== exp) begin
          n_fail++;
          $display("FAIL mem_write_order: got addr=%h data=%h be=%b, required addr=%h data=%h be=%b",
                   mem_wr_addr, mem_wr_data, mem_wr_byte_en, exp.addr, exp.data, exp.be);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input bit expect_push);
    capture_store = 1'b1;
    store_addr    = a;
    store_data    = d;
    store_byte_en = be;
    if (expect_push) sb.push_back('{a, d, be});
    @(posedge clk); #1;
    capture_store = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc = 0;
    mem_wr_ready = 1'b1;
    while (!buffer_empty && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    mem_wr_ready = 1'b0;
    n_checks++;
    if (!buffer_empty || sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_complete: got empty=%b pending=%0d, required empty=1 pending=0",
               buffer_empty, sb.size());
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({buffer_empty, buffer_full, mem_wr_en, forward_valid, forward_stall, misaligned_drop} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_state: got empty,full,wr_en,fv,fs,mis=%b, required 100000",
               {buffer_empty, buffer_full, mem_wr_en, forward_valid, forward_stall, misaligned_drop});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) do_store(32'h80 + 32'(i * 4), 32'hA000_0000 + 32'(i), BE_WORD, 1'b1);
    mem_wr_ready = 1'b1;
    @(posedge clk); #3;
    rst = 1'b1;
    sb.delete();
    #1;
    n_checks++;
    if (buffer_empty !== 1'b1 || mem_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_drain: got empty=%b wr_en=%b, required empty=1 wr_en=0",
               buffer_empty, mem_wr_en);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (buffer_empty !== 1'b1 || mem_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got empty=%b wr_en=%b, required empty=1 wr_en=0",
               buffer_empty, mem_wr_en);
    end
    mem_wr_ready = 1'b0;
  endtask

  task automatic test_fill();
    mem_wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (buffer_full !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_not_full_%0d: got full=%b, required 0", i, buffer_full);
      end
      do_store(32'h100 + 32'(i * 4), 32'h1111_0000 + 32'(i), BE_WORD, 1'b1);
    end
    n_checks++;
    if (buffer_full !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_full: got full=%b, required 1", buffer_full);
    end
    do_store(32'h110, 32'hBAD0_BAD0, BE_WORD, 1'b0);
    n_checks++;
    if (buffer_full !== 1'b1 || mem_wr_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL fill_ignore_fifth: got full=%b head=%h, required full=1 head=00000100",
               buffer_full, mem_wr_addr);
    end
    wait_drain();
  endtask

  task automatic test_forward();
    do_store(32'h200, 32'hDEAD_BEEF, BE_WORD, 1'b1);
    do_store(32'h200, 32'h1234_5678, BE_WORD, 1'b1);
    load_request = 1'b1;
    load_addr    = 32'h200;
    #1;
    n_checks++;
    if (forward_valid !== 1'b1 || forward_data !== 32'h1234_5678 || forward_stall !== 1'b0 || mem_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL forward_youngest: got fv=%b data=%h fs=%b wr_en=%b, required fv=1 data=12345678 fs=0 wr_en=0",
               forward_valid, forward_data, forward_stall, mem_wr_en);
    end
    load_addr = 32'h204;
    #1;
    n_checks++;
    if (forward_valid !== 1'b0 || forward_stall !== 1'b0 || forward_data !== 32'h0) begin
      n_fail++;
      $display("FAIL forward_miss: got fv=%b fs=%b data=%h, required fv=0 fs=0 data=00000000",
               forward_valid, forward_stall, forward_data);
    end
    load_request = 1'b0;
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_partial();
    do_store(32'h300, 32'h0000_00AB, BE_BYTE, 1'b1);
    load_request = 1'b1;
    load_addr    = 32'h300;
    #1;
    n_checks++;
    if (forward_stall !== 1'b1 || forward_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_stall: got fs=%b fv=%b, required fs=1 fv=0", forward_stall, forward_valid);
    end
    load_request = 1'b0;
    @(posedge clk); #1;
    wait_drain();
    load_request = 1'b1;
    #1;
    n_checks++;
    if (forward_stall !== 1'b0 || forward_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_after_drain: got fs=%b fv=%b, required fs=0 fv=0", forward_stall, forward_valid);
    end
    load_request = 1'b0;
    @(posedge clk); #1;
    // Full word with wrong offset, then youngest partial over older full, then the reverse.
    do_store(32'h600, 32'hCAFE_F00D, BE_WORD, 1'b1);
    load_request = 1'b1;
    load_addr    = 32'h602;
    #1;
    n_checks++;
    if (forward_stall !== 1'b1 || forward_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL offset_stall: got fs=%b fv=%b, required fs=1 fv=0", forward_stall, forward_valid);
    end
    load_request = 1'b0;
    @(posedge clk); #1;
    do_store(32'h600, 32'h0000_5555, BE_HALF, 1'b1);
    load_request = 1'b1;
    load_addr    = 32'h600;
    #1;
    n_checks++;
    if (forward_stall !== 1'b1 || forward_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL youngest_partial: got fs=%b fv=%b, required fs=1 fv=0", forward_stall, forward_valid);
    end
    load_request = 1'b0;
    @(posedge clk); #1;
    do_store(32'h600, 32'h7777_8888, BE_WORD, 1'b1);
    load_request = 1'b1;
    #1;
    n_checks++;
    if (forward_valid !== 1'b1 || forward_data !== 32'h7777_8888 || forward_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL youngest_full: got fv=%b data=%h fs=%b, required fv=1 data=77778888 fs=0",
               forward_valid, forward_data, forward_stall);
    end
    load_request = 1'b0;
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_misaligned();
    do_store(32'h402, 32'h5A5A_5A5A, BE_NONE, 1'b0);
    n_checks++;
    if (misaligned_drop !== 1'b1 || buffer_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL misaligned_pulse: got drop=%b empty=%b, required drop=1 empty=1",
               misaligned_drop, buffer_empty);
    end
    @(posedge clk); #1;
    n_checks++;
    if (misaligned_drop !== 1'b0 || buffer_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL misaligned_one_cycle: got drop=%b empty=%b, required drop=0 empty=1",
               misaligned_drop, buffer_empty);
    end
  endtask

  task automatic test_wrap();
    int  sent = 0;
    int  cyc  = 0;
    bit  rdy  = 1'b1;
    logic [3:0] be_tab [3];
    be_tab[0] = BE_WORD;
    be_tab[1] = BE_HALF;
    be_tab[2] = BE_BYTE;
    while (sent < 10 && cyc < 200) begin
      mem_wr_ready = rdy;
      rdy = ~rdy;
      n_checks++;
      if (buffer_full !== (sb.size() == DEPTH) || buffer_empty !== (sb.size() == 0)) begin
        n_fail++;
        $display("FAIL wrap_occupancy: got full=%b empty=%b, required model count=%0d",
                 buffer_full, buffer_empty, sb.size());
      end
      if (!buffer_full) begin
        capture_store = 1'b1;
        store_addr    = 32'h500 + 32'(sent * 4);
        store_data    = $urandom;
        store_byte_en = be_tab[sent % 3];
        sb.push_back('{store_addr, store_data, store_byte_en});
        sent++;
      end else begin
        capture_store = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    capture_store = 1'b0;
    n_checks++;
    if (sent != 10) begin
      n_fail++;
      $display("FAIL wrap_issue_timeout: got %0d stores issued, required 10", sent);
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_forward();
    test_partial();
    test_misaligned();
    test_wrap();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
